// File: rtl/regs_wb_arbiter.sv
// Write-back arbiter and busy scoreboard for the register file's single write port.
// Optional REGS_WB_BYPASS_EN adds forwarding of req1 write-back data to decode.
module regs_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0Valid,
  input  logic [4:0]  req0Num,
  input  logic [31:0] req0Data,
  output logic        req0Ready,
  input  logic        req1Valid,
  input  logic [4:0]  req1Num,
  input  logic [31:0] req1Data,
  output logic        req1Ready,
  input  logic        sbSetEnable,
  input  logic [4:0]  sbSetNum,
  input  logic [4:0]  qNum0,
  input  logic [4:0]  qNum1,
  output logic        stall,
  output logic [31:0] sbBusy,
  output logic        regsWriteEnable,
  output logic [4:0]  regWriteNum,
  output logic [31:0] regWriteData
`ifdef REGS_WB_BYPASS_EN
  ,
  output logic        fwd0Valid,
  output logic [31:0] fwd0Data,
  output logic        fwd1Valid,
  output logic [31:0] fwd1Data
`endif
);

  localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starveCnt_q, starveCnt_d;
  logic [31:0]      sbBusy_q, sbBusy_d;
  logic             wrEn_q;
  logic [4:0]       wrNum_q;
  logic [31:0]      wrData_q;
  logic             starved;

  // req1 overrides req0's fixed priority once it has waited STARVE_LIMIT cycles.
  assign starved   = req1Valid && (starveCnt_q == Limit);
  assign req0Ready = req0Valid && !starved;
  assign req1Ready = req1Valid && (!req0Valid || starved);

  always_comb begin
    starveCnt_d = starveCnt_q;
    if (!req1Valid || req1Ready) begin
      starveCnt_d = '0;
    end else if (starveCnt_q != Limit) begin
      starveCnt_d = starveCnt_q + CNT_W'(1);
    end
  end

  // Clear first, then set, so a new outstanding op wins over a same-cycle completion.
  always_comb begin
    sbBusy_d = sbBusy_q;
    if (req1Ready && (req1Num != 5'd0)) begin
      sbBusy_d[req1Num] = 1'b0;
    end
    if (sbSetEnable && (sbSetNum != 5'd0)) begin
      sbBusy_d[sbSetNum] = 1'b1;
    end
    sbBusy_d[0] = 1'b0;
  end

`ifdef REGS_WB_BYPASS_EN
  logic clr0, clr1;

  assign clr0      = req1Ready && (req1Num == qNum0);
  assign clr1      = req1Ready && (req1Num == qNum1);
  assign fwd0Valid = clr0 && (qNum0 != 5'd0);
  assign fwd1Valid = clr1 && (qNum1 != 5'd0);
  assign fwd0Data  = req1Data;
  assign fwd1Data  = req1Data;
  assign stall     = ((qNum0 != 5'd0) && sbBusy_q[qNum0] && !clr0) ||
                     ((qNum1 != 5'd0) && sbBusy_q[qNum1] && !clr1);
`else
  assign stall = ((qNum0 != 5'd0) && sbBusy_q[qNum0]) ||
                 ((qNum1 != 5'd0) && sbBusy_q[qNum1]);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starveCnt_q <= '0;
      sbBusy_q    <= '0;
      wrEn_q      <= 1'b0;
      wrNum_q     <= '0;
      wrData_q    <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
      sbBusy_q    <= sbBusy_d;
      wrEn_q      <= req0Ready || req1Ready;
      if (req0Ready) begin
        wrNum_q  <= req0Num;
        wrData_q <= req0Data;
      end else if (req1Ready) begin
        wrNum_q  <= req1Num;
        wrData_q <= req1Data;
      end
    end
  end

  assign sbBusy          = sbBusy_q;
  assign regsWriteEnable = wrEn_q;
  assign regWriteNum     = wrNum_q;
  assign regWriteData    = wrData_q;

endmodule

// File: doc/regs_wb_arbiter.md
Name: regs_wb_arbiter

Overview:
Write-back arbiter and scoreboard for the three-ported register file. Two write-back sources share the register file's single write port: the single-cycle ALU pipe (req0) and the long-latency load/store/mul unit (req1). The block grants one source per cycle and drives registered write-port signals to the register file. It keeps a per-register busy scoreboard for outstanding long-latency destinations and gives decode a stall signal.

Parameters:
STARVE_LIMIT, 4, consecutive cycles req1 may be valid-but-denied before it is forced to win (range 1..15)
CNT_W, 4, width of starvation counter

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  asynchronous active-high reset
req0Valid  input  1  ALU write-back request
req0Num  input  5  ALU destination register
req0Data  input  32  ALU write-back data
req0Ready  output  1  grant to req0 (combinational)
req1Valid  input  1  long-latency unit write-back request
req1Num  input  5  LSU/mul destination register
req1Data  input  32  LSU/mul write-back data
req1Ready  output  1  grant to req1 (combinational)
sbSetEnable  input  1  decode issues a long-latency op this cycle
sbSetNum  input  5  its destination register
qNum0  input  5  decode source register 0
qNum1  input  5  decode source register 1
stall  output  1  a source register is busy in the scoreboard
sbBusy  output  32  scoreboard vector; bit 0 always 0
regsWriteEnable  output  1  to register file write enable
regWriteNum  output  5  to register file write index
regWriteData  output  32  to register file write data

Behaviour:
- Reset (async, any time): regsWriteEnable=0, regWriteNum=0, regWriteData=0, sbBusy=0, starvation counter=0. Any in-flight grant is discarded.
- Handshake: a transfer occurs in a cycle when Valid && Ready. A requester holds Valid/Num/Data stable until it is granted. Ready depends only on the two Valid inputs and the starvation counter.
- Arbitration: req0 has fixed priority. The exception is when req1Valid is high and the counter equals STARVE_LIMIT; then req1 wins. At most one Ready is high per cycle. A Ready is never high without its Valid.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each cycle with req1Valid && !req1Ready.
  - Clears on a req1 grant.
  - Clears on any cycle with req1Valid low.
- Output latency: a grant in cycle N produces registered outputs in cycle N+1. regsWriteEnable=1, with Num/Data of the winner. The register file commits on the following negedge. With no grant, regsWriteEnable=0 and Num/Data hold their previous values.
- Grant to x0: the handshake completes and regsWriteEnable=1 with regWriteNum=0. The register file ignores it. There is no scoreboard effect.
- Scoreboard:
  - A posedge with sbSetEnable && sbSetNum!=0 sets sbBusy[sbSetNum].
  - A req1 grant with req1Num!=0 clears sbBusy[req1Num] at the posedge ending the grant cycle.
  - req0 grants never touch the scoreboard.
  - Set and clear of the same register in the same cycle: set wins, because the new op is outstanding.
  - Setting an already-busy register leaves it busy.
- stall = (qNum0!=0 && sbBusy[qNum0]) || (qNum1!=0 && sbBusy[qNum1]). It is purely combinational on current sbBusy. A register cleared this cycle stalls until the next cycle, unless the bypass feature is built in.
- Both Valid low: no grant, outputs idle, counter cleared.

Optional Feature:
REGS_WB_BYPASS_EN.
- Defined: adds outputs fwd0Valid/fwd0Data and fwd1Valid/fwd1Data (1/32 bits each).
  - fwdkValid=1 when a req1 grant is occurring this cycle with req1Num==qNumk!=0; fwdkData=req1Data.
  - stall masks a busy bit whose register is being cleared by that same grant.
- Undefined: ports absent; stall as specified above.

Test Plan:
- Reset mid-stream: assert rst while req0Valid=1, req0Num=5 -> outputs 0 immediately, sbBusy=0; after release, first grant appears one cycle later.
- Single req0 write, Num=3, Data=32'hDEADBEEF -> req0Ready=1 in cycle N; cycle N+1 regsWriteEnable=1, regWriteNum=3, regWriteData=DEADBEEF; cycle N+2 regsWriteEnable=0.
- Both valid continuously, STARVE_LIMIT=4 -> req0 granted for 4 cycles, then req1 granted on cycle 5; counter back to 0, and req0 wins again on cycle 6.
- Scoreboard: sbSetEnable with Num=7; next cycle qNum0=7 -> stall=1; req1 grant with Num=7 -> sbBusy[7]=0 after that posedge, stall=0 the following cycle (bypass undefined).
- Simultaneous sbSetEnable Num=9 and req1 grant Num=9 with bit 9 busy -> sbBusy[9] remains 1.
- x0 handling: sbSetNum=0 -> sbBusy unchanged; req1 grant Num=0 -> regsWriteEnable=1, regWriteNum=0, sbBusy unchanged, stall with qNum0=0 stays 0.
